// File: rtl/signal_extender_sync.sv
// Pulse extender: a multi-flop synchronizer feeds a rising-edge detector, which (re)loads a
// down-counter; pulse_out is registered high while the counter is nonzero.
module signal_extender_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned EXTEND_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic pulse_out
);

    localparam int unsigned CntW = $clog2(EXTEND_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   pulse_out_q, pulse_out_d;
    logic                   rise;

    always_comb begin
        // Stage 0 is the only flop that ever samples pulse_in.
        sync_d      = {sync_q[SYNC_STAGES-2:0], pulse_in};
        hist_d      = sync_q[SYNC_STAGES-1];
        rise        = sync_q[SYNC_STAGES-1] & ~hist_q;
        cnt_d       = cnt_q;
        if (rise) begin
            cnt_d = CntW'(EXTEND_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        pulse_out_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            hist_q      <= 1'b0;
            cnt_q       <= '0;
            pulse_out_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            pulse_out_q <= pulse_out_d;
        end
    end

    assign pulse_out = pulse_out_q;

endmodule

// File: tb/tb_signal_extender_sync.sv
// Bench for signal_extender_sync: default instance plus an EXTEND_CYCLES=1/SYNC_STAGES=3 instance,
// checked against expected pulse_out values queued as stimulus is applied.
module tb_signal_extender_sync;

    localparam int S = 2;
    localparam int E = 4;

    logic clk = 1'b0;
    logic rst1, pin1, pout1;
    logic rst2, pin2, pout2;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    signal_extender_sync dut_def (
        .clk       (clk),
        .rst       (rst1),
        .pulse_in  (pin1),
        .pulse_out (pout1)
    );

    signal_extender_sync #(
        .SYNC_STAGES   (3),
        .EXTEND_CYCLES (1)
    ) dut_bnd (
        .clk       (clk),
        .rst       (rst2),
        .pulse_in  (pin2),
        .pulse_out (pout2)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pop_check(input string tag, input logic got);
        logic e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %b expected none", tag, got);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, got, e);
        end
    endtask

    // pat[k] is pulse_in as captured by edge k (pat[0] is the idle value 0). A rising edge
    // seen at edge k is loaded at edge k+S and keeps pulse_out high after edges e..e+E-1.
    task automatic run_seq(input string tag, input logic [63:0] pat_in, input int n);
        logic [63:0] pat;
        logic [63:0] ld;
        logic        exp;
        pat    = pat_in;
        pat[0] = 1'b0;
        ld     = '0;
        for (int k = 1; k <= n; k++) begin
            if (pat[k] && !pat[k-1] && (k + S) < 64) ld[k+S] = 1'b1;
        end
        for (int m = 1; m <= n; m++) begin
            @(negedge clk);
            pin1 = pat[m];
            exp  = 1'b0;
            for (int e = m - E + 1; e <= m; e++) begin
                if (e >= 1 && ld[e]) exp = 1'b1;
            end
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            pop_check($sformatf("%s[e%0d]", tag, m), pout1);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        pin1 = 1'b0;
        rst2 = 1'b1;
        pin2 = 1'b1;

        // Reset held: pulse_in toggling must not reach pulse_out.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pin1 = ~pin1;
            #2;
            pin1 = ~pin1;
            @(posedge clk);
            #1;
            check_eq("rst_hold", pout1, 1'b0);
            check_eq("rst_hold_bnd", pout2, 1'b0);
        end
        @(negedge clk);
        pin1 = 1'b0;
        rst1 = 1'b0;
        run_seq("idle", 64'd0, 4);

        run_seq("single", 64'b10, 12);
        run_seq("held20", ((64'd1 << 20) - 64'd1) << 1, 30);
        run_seq("retrig", 64'b1010, 14);
        run_seq("two_sep", (64'd1 << 1) | (64'd1 << 10), 20);

        // Reset during the second cycle of an extension.
        @(negedge clk); pin1 = 1'b1;
        @(negedge clk); pin1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_ext_c1", pout1, 1'b1);
        @(posedge clk); #1;
        check_eq("mid_ext_c2", pout1, 1'b1);
        #2;
        rst1 = 1'b1;
        #1;
        check_eq("mid_rst_async", pout1, 1'b0);
        @(posedge clk); #1;
        check_eq("mid_rst_held", pout1, 1'b0);
        @(negedge clk);
        rst1 = 1'b0;
        run_seq("post_rst", 64'd0, 8);

        // Boundary instance: pulse_in already high at reset release.
        @(negedge clk);
        rst2 = 1'b0;
        for (int m = 1; m <= 10; m++) begin
            exp_q.push_back(m == 4);
            @(posedge clk);
            #1;
            pop_check($sformatf("bnd_rel[e%0d]", m), pout2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/signal_extender_sync.md
SIGNAL_EXTENDER_SYNC -- requirements
Module: signal_extender_sync

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter SYNC_STAGES SHALL default to 2 and set the number of synchronizer flops; legal values are 2 or more.
REQ-003 Parameter EXTEND_CYCLES SHALL default to 4 and set the output pulse width in clk cycles; legal values are 1 or more.
REQ-004 Port clk, input, 1 bit: the only clock; all flops capture on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port pulse_in, input, 1 bit: pulse asynchronous to clk; may be narrow or held high.
REQ-007 Port pulse_out, output, 1 bit: extended pulse, synchronous to clk, driven directly from a flop.

Function
REQ-008 pulse_in SHALL pass through a chain of SYNC_STAGES flops before any other logic uses it; nothing else SHALL sample pulse_in.
REQ-009 A history flop SHALL hold the last synchronizer output; a rising edge is detected when the sync output is 1 and the history flop is 0.
REQ-010 A down-counter of width $clog2(EXTEND_CYCLES+1) SHALL be loaded with EXTEND_CYCLES on a detected rising edge.
REQ-011 Otherwise the counter SHALL decrement by 1 while it is nonzero, and SHALL hold at 0 when it is 0 (no wrap-around).
REQ-012 The pulse_out flop SHALL load (next counter value != 0).
REQ-013 Latency: call the clk edge that first captures pulse_in=1 into sync stage 0 edge 1.
- pulse_out SHALL go high after edge SYNC_STAGES+1 (edge 3 at default).
- pulse_out SHALL stay high for exactly EXTEND_CYCLES cycles.
REQ-014 A pulse_in held high for any duration SHALL produce exactly one extension; the level does not re-trigger.
REQ-015 Retrigger: a new rising edge detected while the counter is nonzero SHALL reload EXTEND_CYCLES.
- pulse_out SHALL stay high with no gap.
- pulse_out SHALL fall EXTEND_CYCLES cycles after the last detected edge.
REQ-016 A load and a decrement in the same cycle SHALL resolve to the load.
REQ-017 pulse_in pulses shorter than one clk period are not guaranteed to be captured.
- Any pulse that is high for at least one full clk period including setup/hold SHALL be captured.

Reset
REQ-018 While rst=1, the synchronizer chain, the history flop, the counter and pulse_out SHALL all be 0.
- This SHALL take effect immediately, without waiting for a clk edge.
REQ-019 rst asserted mid-extension SHALL drop pulse_out to 0 at once, and the extension SHALL be discarded, not resumed.
REQ-020 rst deassertion SHALL be synchronous to clk; that is the integrator's responsibility.
REQ-021 If pulse_in is already high when rst is released, it SHALL be treated as a rising edge.
- Exactly one extension SHALL follow, with the REQ-013 latency.

Verification
REQ-022 Reset: hold rst=1 and toggle pulse_in freely -> pulse_out=0 throughout.
REQ-023 Single pulse, defaults: pulse_in high for one clk cycle -> pulse_out high after edge 3, for exactly 4 cycles, then 0.
REQ-024 Held level, defaults: pulse_in high for 20 cycles -> one 4-cycle pulse_out pulse only.
REQ-025 Retrigger, defaults: two 1-cycle pulses with edges 2 cycles apart -> pulse_out continuously high for 6 cycles.
REQ-026 Reset mid-operation: assert rst during cycle 2 of an extension -> pulse_out=0 immediately; it stays 0 after release with pulse_in=0.
REQ-027 Boundary, EXTEND_CYCLES=1 and SYNC_STAGES=3: pulse_in high through rst release -> one 1-cycle pulse_out after edge 4 following release.
